// File: rtl/delay_scheduler.sv
// ---------------------------------------------------------------------------
// delay_scheduler
//
// Holds a shadow copy of per-tap delay indices for a microphone beamformer and
// copies the whole shadow set into the active delay_index bus atomically at an
// audio frame boundary (falling edge of ws). Writes land in the shadow only;
// a write with cfg_commit arms the transfer, which happens at the next ws fall
// seen after the arming edge.
//
// Optional feature: define DELAY_SCHEDULER_READBACK_EN to add a combinational
// shadow readback port (rd_tap -> rd_delay).
//
// Ports
//   clk          in   system clock, rising-edge active
//   reset        in   asynchronous active-high reset
//   ws           in   word select; falling edge marks the frame boundary
//   cfg_valid    in   configuration write request
//   cfg_ready    out  high when a write can be accepted (IDLE only)
//   cfg_tap      in   tap number to write (3 bits)
//   cfg_delay    in   new delay index for that tap
//   cfg_commit   in   arm an atomic update at the next frame boundary
//   delay_index  out  active indices, tap k at [k*INDEX_WIDTH +: INDEX_WIDTH]
//   pending      out  high while a committed update waits for a frame boundary
//   applied      out  one-cycle pulse after the active indices were updated
//   err          out  sticky flag: a write addressed a nonexistent tap
//   rd_tap       in   (readback only) shadow tap to read
//   rd_delay     out  (readback only) shadow[rd_tap], 0 for nonexistent taps
// ---------------------------------------------------------------------------
module delay_scheduler #(
    parameter int NUM_TAPS    = 6,
    parameter int INDEX_WIDTH = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ws,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [2:0]                      cfg_tap,
    input  logic [INDEX_WIDTH-1:0]          cfg_delay,
    input  logic                            cfg_commit,
    output logic [NUM_TAPS*INDEX_WIDTH-1:0] delay_index,
    output logic                            pending,
    output logic                            applied,
    output logic                            err
`ifdef DELAY_SCHEDULER_READBACK_EN
    ,
    input  logic [2:0]                      rd_tap,
    output logic [INDEX_WIDTH-1:0]          rd_delay
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] shadow [NUM_TAPS];
    logic                   ws_q1;
    logic                   ws_q2;
    logic                   fall;
    logic                   xfer;
    logic                   tap_ok;

    // Both synchroniser flops clear on reset, so ws held high across reset
    // release cannot look like a fall until it is seen high and then low.
    assign fall   = ws_q2 & ~ws_q1;
    assign xfer   = cfg_valid & cfg_ready;
    assign tap_ok = int'(cfg_tap) < NUM_TAPS;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cfg_ready   <= 1'b1;
            pending     <= 1'b0;
            applied     <= 1'b0;
            err         <= 1'b0;
            ws_q1       <= 1'b0;
            ws_q2       <= 1'b0;
            delay_index <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            ws_q1 <= ws;
            ws_q2 <= ws_q1;

            case (state)
                // Accept writes. A fall here is ignored, so a commit taken on
                // the same edge as a fall waits for the following frame.
                IDLE: begin
                    if (xfer) begin
                        if (tap_ok) begin
                            for (int k = 0; k < NUM_TAPS; k++) begin
                                if (int'(cfg_tap) == k) begin
                                    shadow[k] <= cfg_delay;
                                end
                            end
                        end else begin
                            err <= 1'b1;
                        end
                        // Commit arms even if the write itself was discarded.
                        if (cfg_commit) begin
                            state     <= ARMED;
                            cfg_ready <= 1'b0;
                            pending   <= 1'b1;
                        end
                    end
                end

                // Wait for the frame boundary, then copy every tap at once.
                ARMED: begin
                    if (fall) begin
                        for (int k = 0; k < NUM_TAPS; k++) begin
                            delay_index[k*INDEX_WIDTH +: INDEX_WIDTH] <= shadow[k];
                        end
                        state   <= APPLY;
                        pending <= 1'b0;
                        applied <= 1'b1;
                    end
                end

                APPLY: begin
                    state     <= IDLE;
                    applied   <= 1'b0;
                    cfg_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    pending   <= 1'b0;
                    applied   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DELAY_SCHEDULER_READBACK_EN
    always_comb begin
        rd_delay = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (int'(rd_tap) == k) begin
                rd_delay = shadow[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_delay_scheduler.sv
// ---------------------------------------------------------------------------
// tb_delay_scheduler
//
// Directed bench for delay_scheduler. Inputs change 1 time unit after the
// rising clock edge and outputs are sampled there too, away from the edge.
// ---------------------------------------------------------------------------
module tb_delay_scheduler;

    localparam int NT = 6;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             ws;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_tap;
    logic [IW-1:0]    cfg_delay;
    logic             cfg_commit;
    logic [NT*IW-1:0] delay_index;
    logic             pending;
    logic             applied;
    logic             err;
`ifdef DELAY_SCHEDULER_READBACK_EN
    logic [2:0]       rd_tap;
    logic [IW-1:0]    rd_delay;
`endif

    int errors = 0;
    int checks = 0;

    delay_scheduler #(.NUM_TAPS(NT), .INDEX_WIDTH(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ws         (ws),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_tap    (cfg_tap),
        .cfg_delay  (cfg_delay),
        .cfg_commit (cfg_commit),
        .delay_index(delay_index),
        .pending    (pending),
        .applied    (applied),
        .err        (err)
`ifdef DELAY_SCHEDULER_READBACK_EN
        ,
        .rd_tap     (rd_tap),
        .rd_delay   (rd_delay)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        ws         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_tap    = '0;
        cfg_delay  = '0;
        cfg_commit = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic cfg_write(input logic [2:0] t, input logic [IW-1:0] d, input logic c);
        cfg_valid  = 1'b1;
        cfg_tap    = t;
        cfg_delay  = d;
        cfg_commit = c;
        step();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Raise ws long enough to settle, then drop it; returns in the cycle
    // where the synchronised fall is visible (the next edge applies).
    task automatic ws_drop();
        ws = 1'b1;
        repeat (3) step();
        ws = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ws         = 1'b1;
        cfg_valid  = 1'b0;
        cfg_tap    = '0;
        cfg_delay  = '0;
        cfg_commit = 1'b0;
        repeat (2) step();
        checks++; if (delay_index !== 18'h0) begin errors++; $display("FAIL rst_delay_index: got %h want %h", delay_index, 18'h0); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b want 0", pending); end
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL rst_applied: got %b want 0", applied); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        // Release with ws still high and commit immediately: no spurious fall.
        reset = 1'b0;
        cfg_write(3'd0, 3'd2, 1'b1);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rst_arm_pending: got %b want 1", pending); end
        repeat (4) step();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rst_ws_high_pending: got %b want 1", pending); end
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL rst_ws_high_applied: got %b want 0", applied); end
        ws_drop();
        step();
        checks++; if (applied !== 1'b1) begin errors++; $display("FAIL rst_first_apply: got %b want 1", applied); end
        checks++; if (delay_index !== 18'h2) begin errors++; $display("FAIL rst_first_index: got %h want %h", delay_index, 18'h2); end
    endtask

    task automatic test_no_commit();
        logic saw_applied;
        logic saw_change;
        apply_reset();
        cfg_write(3'd2, 3'd5, 1'b0);
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL nocommit_pending: got %b want 0", pending); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL nocommit_ready: got %b want 1", cfg_ready); end
        saw_applied = 1'b0;
        saw_change  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            ws = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                if (applied) saw_applied = 1'b1;
                if (delay_index != 18'h0) saw_change = 1'b1;
            end
            ws = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (applied) saw_applied = 1'b1;
                if (delay_index != 18'h0) saw_change = 1'b1;
            end
        end
        checks++; if (saw_applied !== 1'b0) begin errors++; $display("FAIL nocommit_applied: got %b want 0", saw_applied); end
        checks++; if (saw_change !== 1'b0) begin errors++; $display("FAIL nocommit_index: delay_index changed, last %h want 0", delay_index); end
    endtask

    task automatic test_commit();
        apply_reset();
        cfg_write(3'd0, 3'd3, 1'b0);
        cfg_write(3'd5, 3'd7, 1'b1);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL commit_pending: got %b want 1", pending); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b want 0", cfg_ready); end
        ws_drop();
        checks++; if (delay_index !== 18'h0) begin errors++; $display("FAIL commit_early: got %h want %h", delay_index, 18'h0); end
        step();
        checks++; if (delay_index !== 18'h38003) begin errors++; $display("FAIL commit_index: got %h want %h", delay_index, 18'h38003); end
        checks++; if (applied !== 1'b1) begin errors++; $display("FAIL commit_applied: got %b want 1", applied); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL commit_pending_low: got %b want 0", pending); end
        step();
        checks++; if (applied !== 1'b0) begin errors++; $display("FAIL commit_applied_pulse: got %b want 0", applied); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL commit_ready_back: got %b want 1", cfg_ready); end
        checks++; if (delay_index !== 18'h38003) begin errors++; $display("FAIL commit_index_hold: got %h want %h", delay_index, 18'h38003); end
    endtask

    task automatic test_same_cycle_commit();
        logic early;
        apply_reset();
        ws = 1'b1;
        repeat (3) step();
        ws = 1'b0;
        step();
        // fall is active in this cycle; the commit edge must only arm
        cfg_write(3'd1, 3'd4, 1'b1);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL same_pending: got %b want 1", pending); end
        early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (applied || delay_index != 18'h0) early = 1'b1;
            step();
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL same_no_apply: got index %h applied %b want 0", delay_index, applied); end
        ws_drop();
        step();
        checks++; if (delay_index !== 18'h20) begin errors++; $display("FAIL same_next_fall: got %h want %h", delay_index, 18'h20); end
        checks++; if (applied !== 1'b1) begin errors++; $display("FAIL same_applied: got %b want 1", applied); end
    endtask

    task automatic test_bad_tap();
        apply_reset();
        cfg_write(3'd1, 3'd2, 1'b0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_err_clean: got %b want 0", err); end
        cfg_write(3'd6, 3'd5, 1'b1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b want 1", err); end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL bad_pending: got %b want 1", pending); end
        ws_drop();
        step();
        checks++; if (applied !== 1'b1) begin errors++; $display("FAIL bad_applied: got %b want 1", applied); end
        checks++; if (delay_index !== 18'h10) begin errors++; $display("FAIL bad_index: got %h want %h", delay_index, 18'h10); end
        step();
        cfg_write(3'd7, 3'd1, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b want 1", err); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %b want 1", cfg_ready); end
        // Reset clears without waiting for a clock edge.
        reset = 1'b1;
        #1;
        checks++; if (delay_index !== 18'h0) begin errors++; $display("FAIL async_index: got %h want %h", delay_index, 18'h0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b want 0", err); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_armed();
        logic saw_applied;
        logic saw_pending;
        apply_reset();
        cfg_write(3'd3, 3'd2, 1'b1);
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rarm_pending: got %b want 1", pending); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rarm_async_pending: got %b want 0", pending); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rarm_async_ready: got %b want 1", cfg_ready); end
        step();
        reset = 1'b0;
        saw_applied = 1'b0;
        saw_pending = 1'b0;
        for (int n = 0; n < 2; n++) begin
            ws = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                if (applied) saw_applied = 1'b1;
                if (pending) saw_pending = 1'b1;
            end
            ws = 1'b0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (applied) saw_applied = 1'b1;
                if (pending) saw_pending = 1'b1;
            end
        end
        checks++; if (saw_applied !== 1'b0) begin errors++; $display("FAIL rarm_applied: got %b want 0", saw_applied); end
        checks++; if (saw_pending !== 1'b0) begin errors++; $display("FAIL rarm_pending_after: got %b want 0", saw_pending); end
        checks++; if (delay_index !== 18'h0) begin errors++; $display("FAIL rarm_index: got %h want %h", delay_index, 18'h0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rarm_err: got %b want 0", err); end
    endtask

    task automatic test_held_valid();
        logic ready_seen;
        apply_reset();
        cfg_write(3'd0, 3'd1, 1'b1);
        cfg_valid  = 1'b1;
        cfg_tap    = 3'd4;
        cfg_delay  = 3'd6;
        cfg_commit = 1'b0;
        ready_seen = 1'b0;
        ws = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cfg_ready) ready_seen = 1'b1;
            step();
        end
        ws = 1'b0;
        if (cfg_ready) ready_seen = 1'b1;
        step();
        if (cfg_ready) ready_seen = 1'b1;
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL held_ready_armed: got %b want 0", ready_seen); end
        step();
        checks++; if (applied !== 1'b1) begin errors++; $display("FAIL held_applied: got %b want 1", applied); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL held_ready_apply: got %b want 0", cfg_ready); end
        checks++; if (delay_index !== 18'h1) begin errors++; $display("FAIL held_index: got %h want %h", delay_index, 18'h1); end
        step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL held_ready_idle: got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL held_no_arm: got %b want 0", pending); end
        checks++; if (delay_index !== 18'h1) begin errors++; $display("FAIL held_index_hold: got %h want %h", delay_index, 18'h1); end
`ifdef DELAY_SCHEDULER_READBACK_EN
        rd_tap = 3'd4;
        #1;
        checks++; if (rd_delay !== 3'd6) begin errors++; $display("FAIL rd_tap4: got %0d want 6", rd_delay); end
        rd_tap = 3'd6;
        #1;
        checks++; if (rd_delay !== 3'd0) begin errors++; $display("FAIL rd_tap6: got %0d want 0", rd_delay); end
        rd_tap = 3'd0;
`endif
        cfg_write(3'd0, 3'd1, 1'b1);
        ws_drop();
        step();
        checks++; if (delay_index !== 18'h6001) begin errors++; $display("FAIL held_accepted: got %h want %h", delay_index, 18'h6001); end
    endtask

    initial begin
`ifdef DELAY_SCHEDULER_READBACK_EN
        rd_tap = 3'd0;
`endif
        test_reset();
        test_no_commit();
        test_commit();
        test_same_cycle_commit();
        test_bad_tap();
        test_reset_armed();
        test_held_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
